// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colour bit position and the video palette.
package chess_pkg;

    typedef enum logic [2:0] {
        PIECE_EMPTY  = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6,
        PIECE_NONE   = 3'd7
    } piece_type_e;

    localparam int PIECE_COLOR_BIT = 3;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t PAL_BLACK       = '{r: 3'd0, g: 3'd0, b: 2'd0};
    localparam rgb_t PAL_LIGHT       = '{r: 3'd5, g: 3'd4, b: 2'd1};
    localparam rgb_t PAL_DARK        = '{r: 3'd3, g: 3'd2, b: 2'd0};
    localparam rgb_t PAL_WHITE_PIECE = '{r: 3'd7, g: 3'd7, b: 2'd3};
    localparam rgb_t PAL_BLACK_PIECE = '{r: 3'd0, g: 3'd0, b: 2'd0};
    localparam rgb_t PAL_CURSOR      = '{r: 3'd7, g: 3'd7, b: 2'd0};
    localparam rgb_t PAL_SELECT      = '{r: 3'd7, g: 3'd0, b: 2'd0};

    function automatic logic pieceIsEmpty(input logic [2:0] pieceType);
        return (pieceType == PIECE_EMPTY) || (pieceType == PIECE_NONE);
    endfunction

endpackage

// File: rtl/piece_sprite_rom.sv
// 8x8 piece bitmaps, one registered row per read; row 0 is the top, bit 7 the leftmost pixel.
module piece_sprite_rom
    import chess_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] type_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    // Each word holds the bitmap with the top row in the most significant byte.
    localparam logic [63:0] SPR_PAWN   = 64'h00_18_3C_18_18_3C_7E_00;
    localparam logic [63:0] SPR_KNIGHT = 64'h00_1C_3E_76_1E_3C_7E_00;
    localparam logic [63:0] SPR_BISHOP = 64'h18_3C_2C_34_3C_18_7E_00;
    localparam logic [63:0] SPR_ROOK   = 64'h5A_7E_3C_3C_3C_3C_7E_00;
    localparam logic [63:0] SPR_QUEEN  = 64'h5A_5A_7E_3C_3C_3C_7E_00;
    localparam logic [63:0] SPR_KING   = 64'h18_7E_18_3C_3C_3C_7E_00;

    logic [63:0] spriteWord;
    logic [7:0]  bits_d;
    logic [7:0]  bits_q;

    always_comb begin
        spriteWord = '0;
        case (piece_type_e'(type_i))
            PIECE_PAWN:   spriteWord = SPR_PAWN;
            PIECE_KNIGHT: spriteWord = SPR_KNIGHT;
            PIECE_BISHOP: spriteWord = SPR_BISHOP;
            PIECE_ROOK:   spriteWord = SPR_ROOK;
            PIECE_QUEEN:  spriteWord = SPR_QUEEN;
            PIECE_KING:   spriteWord = SPR_KING;
            default:      spriteWord = '0;
        endcase
        bits_d = spriteWord[{~row_i, 3'b000} +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/board_renderer.sv
// VGA chessboard renderer: sync timing, per-frame input snapshot and a 3-stage pixel pipeline.
module board_renderer
    import chess_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int N        = 8,
    parameter int TILE     = 50,
    parameter int BOARD_X0 = 120,
    parameter int BOARD_Y0 = 40,
    parameter int SCALE    = 5,
    localparam int AW      = $clog2(N * N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [4*N*N-1:0]  board_i,
    input  logic [AW-1:0]     cursor_addr_i,
    input  logic [AW-1:0]     select_addr_i,
    input  logic              select_en_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [2:0]        r_o,
    output logic [2:0]        g_o,
    output logic [1:0]        b_o,
    output logic              frame_start_o
);

    localparam int HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(HTOT);
    localparam int VW     = $clog2(VTOT);
    localparam int CW     = (N > 1) ? $clog2(N) : 1;
    localparam int OW     = $clog2(TILE);
    localparam int SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int MARGIN = (TILE - 8 * SCALE) / 2;

    if (BOARD_X0 + N * TILE > H_ACTIVE) begin : g_errWidth
        $error("board_renderer: board does not fit horizontally");
    end
    if (BOARD_Y0 + N * TILE > V_ACTIVE) begin : g_errHeight
        $error("board_renderer: board does not fit vertically");
    end
    if (8 * SCALE > TILE - 4) begin : g_errSprite
        $error("board_renderer: sprite too large for tile");
    end

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          lineEnd;

    logic          xIn_q, xIn_d, yIn_q, yIn_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [OW-1:0] xoff_q, xoff_d, yoff_q, yoff_d;
    logic [2:0]    sprCol_q, sprCol_d, sprRow_q, sprRow_d;
    logic [SW-1:0] subX_q, subX_d, subY_q, subY_d;

    logic [4*N*N-1:0] boardShadow_q;
    logic [AW-1:0]    cursorShadow_q, selectShadow_q;
    logic             selEnShadow_q;
    logic             snapshot;

    always_comb begin
        lineEnd = (hcnt_q == HW'(HTOT - 1));
        hcnt_d  = lineEnd ? '0 : hcnt_q + HW'(1);
        vcnt_d  = vcnt_q;
        if (lineEnd) begin
            vcnt_d = (vcnt_q == VW'(VTOT - 1)) ? '0 : vcnt_q + VW'(1);
        end
    end

    // Horizontal tile walk: the registered trackers always describe the pixel at hcnt_q.
    always_comb begin
        xIn_d  = xIn_q;
        col_d  = col_q;
        xoff_d = xoff_q;
        if (hcnt_d == HW'(BOARD_X0)) begin
            xIn_d  = 1'b1;
            col_d  = '0;
            xoff_d = '0;
        end else if (xIn_q) begin
            if (xoff_q == OW'(TILE - 1)) begin
                xoff_d = '0;
                if (col_q == CW'(N - 1)) begin
                    xIn_d = 1'b0;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                xoff_d = xoff_q + OW'(1);
            end
        end
        sprCol_d = sprCol_q;
        subX_d   = subX_q;
        if (xoff_d == OW'(MARGIN)) begin
            sprCol_d = '0;
            subX_d   = '0;
        end else if (subX_q == SW'(SCALE - 1)) begin
            subX_d   = '0;
            sprCol_d = sprCol_q + 3'd1;
        end else begin
            subX_d = subX_q + SW'(1);
        end
    end

    // Vertical walk mirrors the horizontal one but only steps at the end of a line.
    always_comb begin
        yIn_d    = yIn_q;
        row_d    = row_q;
        yoff_d   = yoff_q;
        sprRow_d = sprRow_q;
        subY_d   = subY_q;
        if (lineEnd) begin
            if (vcnt_d == VW'(BOARD_Y0)) begin
                yIn_d  = 1'b1;
                row_d  = '0;
                yoff_d = '0;
            end else if (yIn_q) begin
                if (yoff_q == OW'(TILE - 1)) begin
                    yoff_d = '0;
                    if (row_q == CW'(N - 1)) begin
                        yIn_d = 1'b0;
                    end else begin
                        row_d = row_q + CW'(1);
                    end
                end else begin
                    yoff_d = yoff_q + OW'(1);
                end
            end
            if (yoff_d == OW'(MARGIN)) begin
                sprRow_d = '0;
                subY_d   = '0;
            end else if (subY_q == SW'(SCALE - 1)) begin
                subY_d   = '0;
                sprRow_d = sprRow_q + 3'd1;
            end else begin
                subY_d = subY_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            xIn_q    <= (BOARD_X0 == 0);
            yIn_q    <= (BOARD_Y0 == 0);
            col_q    <= '0;
            row_q    <= '0;
            xoff_q   <= '0;
            yoff_q   <= '0;
            sprCol_q <= '0;
            sprRow_q <= '0;
            subX_q   <= '0;
            subY_q   <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            xIn_q    <= xIn_d;
            yIn_q    <= yIn_d;
            col_q    <= col_d;
            row_q    <= row_d;
            xoff_q   <= xoff_d;
            yoff_q   <= yoff_d;
            sprCol_q <= sprCol_d;
            sprRow_q <= sprRow_d;
            subX_q   <= subX_d;
            subY_q   <= subY_d;
        end
    end

    assign snapshot      = (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE));
    assign frame_start_o = snapshot;

    // Shadow copies change only at the start of vertical blanking so a frame never tears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            boardShadow_q  <= '0;
            cursorShadow_q <= '0;
            selectShadow_q <= '0;
            selEnShadow_q  <= 1'b0;
        end else if (snapshot) begin
            boardShadow_q  <= board_i;
            cursorShadow_q <= cursor_addr_i;
            selectShadow_q <= select_addr_i;
            selEnShadow_q  <= select_en_i;
        end
    end

    logic          s1Vis, s1Border, s1InSpr, s1Light;
    logic [AW-1:0] s1Addr;
    logic [2:0]    s1SprCol, s1SprRow;
    logic          s1Vis_q, s1Border_q, s1InSpr_q, s1Light_q;
    logic [AW-1:0] s1Addr_q;
    logic [2:0]    s1SprCol_q, s1SprRow_q;

    always_comb begin
        s1Vis    = xIn_q && yIn_q;
        s1Border = (xoff_q < OW'(2)) || (xoff_q >= OW'(TILE - 2)) ||
                   (yoff_q < OW'(2)) || (yoff_q >= OW'(TILE - 2));
        s1InSpr  = (xoff_q >= OW'(MARGIN)) && (xoff_q < OW'(MARGIN + 8 * SCALE)) &&
                   (yoff_q >= OW'(MARGIN)) && (yoff_q < OW'(MARGIN + 8 * SCALE));
        s1Light  = ~(row_q[0] ^ col_q[0]);
        s1Addr   = AW'(row_q) * AW'(N) + AW'(col_q);
        s1SprCol = sprCol_q;
        s1SprRow = sprRow_q;
    end

    logic          s2Vis_q, s2Cursor_q, s2Select_q, s2Border_q, s2InSpr_q, s2Light_q;
    logic [2:0]    s2SprCol_q;
    logic [3:0]    s2Piece_q;
    logic [3:0]    s1Piece;
    logic [7:0]    spriteBits;

    assign s1Piece = boardShadow_q[{s1Addr_q, 2'b00} +: 4];

    piece_sprite_rom u_spriteRom (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .type_i (s1Piece[2:0]),
        .row_i  (s1SprRow_q),
        .bits_o (spriteBits)
    );

    rgb_t pixel_d, pixel_q;
    logic spriteHit;

    always_comb begin
        spriteHit = s2InSpr_q && spriteBits[~s2SprCol_q] && !pieceIsEmpty(s2Piece_q[2:0]);
        pixel_d   = PAL_BLACK;
        if (!s2Vis_q) begin
            pixel_d = PAL_BLACK;
        end else if (s2Cursor_q && s2Border_q) begin
            pixel_d = PAL_CURSOR;
        end else if (s2Select_q && s2Border_q) begin
            pixel_d = PAL_SELECT;
        end else if (spriteHit) begin
            pixel_d = s2Piece_q[PIECE_COLOR_BIT] ? PAL_BLACK_PIECE : PAL_WHITE_PIECE;
        end else begin
            pixel_d = s2Light_q ? PAL_LIGHT : PAL_DARK;
        end
    end

    logic syncH, syncV;
    logic [2:0] hsyncPipe_q, vsyncPipe_q;

    always_comb begin
        syncH = ((hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)))
                ? SYNC_POL : ~SYNC_POL;
        syncV = ((vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)))
                ? SYNC_POL : ~SYNC_POL;
    end

    // Pipeline stages; sync travels alongside so it stays aligned with colour.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1Vis_q     <= 1'b0;
            s1Border_q  <= 1'b0;
            s1InSpr_q   <= 1'b0;
            s1Light_q   <= 1'b0;
            s1Addr_q    <= '0;
            s1SprCol_q  <= '0;
            s1SprRow_q  <= '0;
            s2Vis_q     <= 1'b0;
            s2Cursor_q  <= 1'b0;
            s2Select_q  <= 1'b0;
            s2Border_q  <= 1'b0;
            s2InSpr_q   <= 1'b0;
            s2Light_q   <= 1'b0;
            s2SprCol_q  <= '0;
            s2Piece_q   <= '0;
            pixel_q     <= PAL_BLACK;
            hsyncPipe_q <= {3{~SYNC_POL}};
            vsyncPipe_q <= {3{~SYNC_POL}};
        end else begin
            s1Vis_q     <= s1Vis;
            s1Border_q  <= s1Border;
            s1InSpr_q   <= s1InSpr;
            s1Light_q   <= s1Light;
            s1Addr_q    <= s1Addr;
            s1SprCol_q  <= s1SprCol;
            s1SprRow_q  <= s1SprRow;
            s2Vis_q     <= s1Vis_q;
            s2Cursor_q  <= (s1Addr_q == cursorShadow_q);
            s2Select_q  <= (s1Addr_q == selectShadow_q) && selEnShadow_q;
            s2Border_q  <= s1Border_q;
            s2InSpr_q   <= s1InSpr_q;
            s2Light_q   <= s1Light_q;
            s2SprCol_q  <= s1SprCol_q;
            s2Piece_q   <= s1Piece;
            pixel_q     <= pixel_d;
            hsyncPipe_q <= {hsyncPipe_q[1:0], syncH};
            vsyncPipe_q <= {vsyncPipe_q[1:0], syncV};
        end
    end

    assign hsync_o = hsyncPipe_q[2];
    assign vsync_o = vsyncPipe_q[2];
    assign r_o     = pixel_q.r;
    assign g_o     = pixel_q.g;
    assign b_o     = pixel_q.b;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer using a reduced video mode so several frames run quickly.
module tb_board_renderer;

    localparam int HA = 96, HF = 4, HS = 8, HB = 4;
    localparam int VA = 88, VF = 2, VS = 2, VB = 2;
    localparam int NT = 4, TL = 20, SC = 2, X0 = 8, Y0 = 4;
    localparam int LINE  = HA + HF + HS + HB;
    localparam int FRAME = LINE * (VA + VF + VS + VB);
    localparam int SNAP  = VA * LINE;

    localparam logic [7:0] C_BLACK  = 8'b000_000_00;
    localparam logic [7:0] C_LIGHT  = 8'b101_100_01;
    localparam logic [7:0] C_DARK   = 8'b011_010_00;
    localparam logic [7:0] C_WHITE  = 8'b111_111_11;
    localparam logic [7:0] C_CURSOR = 8'b111_111_00;
    localparam logic [7:0] C_SELECT = 8'b111_000_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] board;
    logic [3:0]  cursor, selAddr;
    logic        selEn;
    logic        hsync, vsync, frameStart;
    logic [2:0]  r, g;
    logic [1:0]  b;

    int checks = 0;
    int errors = 0;
    int cyc;
    int lows;

    board_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .N(NT), .TILE(TL),
        .BOARD_X0(X0), .BOARD_Y0(Y0), .SCALE(SC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .board_i(board),
        .cursor_addr_i(cursor), .select_addr_i(selAddr), .select_en_i(selEn),
        .hsync_o(hsync), .vsync_o(vsync), .r_o(r), .g_o(g), .b_o(b),
        .frame_start_o(frameStart)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] brd, input logic [3:0] cur,
                                 input logic [3:0] sel, input logic en);
        board   = brd;
        cursor  = cur;
        selAddr = sel;
        selEn   = en;
    endtask

    task automatic waitCycle(input int target);
        int guard = 0;
        while (cyc < target && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) checkOutput("cycle_sync", cyc, target);
    endtask

    task automatic checkPixel(input string tag, input int base, input int x, input int y,
                              input logic [7:0] expected);
        waitCycle(base + y * LINE + x + 3);
        checkOutput(tag, {24'd0, r, g, b}, {24'd0, expected});
    endtask

    initial begin
        applyStimulus(64'd0, 4'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_hsync", hsync, 1);
        checkOutput("rst_vsync", vsync, 1);
        checkOutput("rst_rgb", {r, g, b}, 0);
        checkOutput("rst_fs", frameStart, 0);

        rst_n = 1'b1;
        applyStimulus(64'h1, 4'd9, 4'd9, 1'b1);

        waitCycle(102); checkOutput("hsync_pre", hsync, 1);
        waitCycle(103); checkOutput("hsync_first", hsync, 0);
        waitCycle(110); checkOutput("hsync_last", hsync, 0);
        waitCycle(111); checkOutput("hsync_post", hsync, 1);
        waitCycle(LINE);
        lows = 0;
        for (int i = 0; i < LINE; i++) begin
            if (!hsync) lows++;
            @(negedge clk);
        end
        checkOutput("hsync_width", lows, HS);

        checkPixel("f0_cursor_tile0", 0, 8, 4, C_CURSOR);
        checkPixel("f0_left_blank", 0, 7, 9, C_BLACK);
        checkPixel("f0_light", 0, 13, 9, C_LIGHT);
        checkPixel("f0_dark", 0, 33, 9, C_DARK);
        checkPixel("f0_right_blank", 0, 90, 9, C_BLACK);

        waitCycle(SNAP - 1); checkOutput("fs_before", frameStart, 0);
        waitCycle(SNAP);     checkOutput("fs_pulse", frameStart, 1);
        waitCycle(SNAP + 1); checkOutput("fs_after", frameStart, 0);
        waitCycle(89 * LINE + 23); checkOutput("vsync_pre", vsync, 1);
        waitCycle(90 * LINE + 23); checkOutput("vsync_low", vsync, 0);
        waitCycle(92 * LINE + 23); checkOutput("vsync_post", vsync, 1);

        checkPixel("f1_tile0_border", FRAME, 8, 4, C_LIGHT);
        checkPixel("f1_pawn_row0", FRAME, 10, 6, C_LIGHT);
        checkPixel("f1_pawn_gap", FRAME, 12, 8, C_LIGHT);
        checkPixel("f1_pawn_set", FRAME, 16, 8, C_WHITE);
        waitCycle(FRAME + 10 * LINE);
        applyStimulus(64'hC, 4'd9, 4'd10, 1'b1);
        checkPixel("f1_no_tear", FRAME, 16, 16, C_WHITE);
        checkPixel("f1_cursor_wins", FRAME, 28, 50, C_CURSOR);
        checkPixel("f1_old_select", FRAME, 48, 50, C_LIGHT);
        checkPixel("f1_dark_tile9", FRAME, 38, 54, C_DARK);
        waitCycle(FRAME + SNAP); checkOutput("fs_frame1", frameStart, 1);

        checkPixel("f2_rook_gap", 2 * FRAME, 12, 16, C_LIGHT);
        checkPixel("f2_black_rook", 2 * FRAME, 16, 16, C_BLACK);
        checkPixel("f2_cursor", 2 * FRAME, 28, 50, C_CURSOR);
        checkPixel("f2_select", 2 * FRAME, 48, 50, C_SELECT);
        waitCycle(2 * FRAME + 60 * LINE + 30);
        checkOutput("prereset_rgb", {r, g, b}, C_LIGHT);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rgb", {r, g, b}, 0);
        checkOutput("midrst_hsync", hsync, 1);
        checkOutput("midrst_vsync", vsync, 1);
        checkOutput("midrst_fs", frameStart, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        checkPixel("r0_cursor_tile0", 0, 8, 4, C_CURSOR);
        checkPixel("r0_empty_shadow", 0, 16, 16, C_LIGHT);
        waitCycle(SNAP - 1); checkOutput("r_fs_before", frameStart, 0);
        waitCycle(SNAP);     checkOutput("r_fs_pulse", frameStart, 1);
        checkPixel("r1_black_rook", FRAME, 16, 16, C_BLACK);
        checkPixel("r1_select", FRAME, 48, 50, C_SELECT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
